// File: rtl/bp_pkg.sv
// ----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the block-packing group controller and its encoder.
// Contents:
//   state_t  - controller FSM states (COLLECT, ENCODE, EMIT, FLUSH)
//   HDR_W    - width of the per-group Bits_req header
//   ACC_W    - width of the output bit accumulator
//   FILL_W   - width of the accumulator fill counter
//   MIN_BITS - smallest field width a non-skip group may use
//   ECG_TWOS - ecgidx code that selects two's-complement coding
//   bit_len  - number of significant bits in an unsigned value
// ----------------------------------------------------------------------------
package bp_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_ENCODE  = 2'd1,
        ST_EMIT    = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    localparam int          HDR_W    = 4;
    localparam int          ACC_W    = 64;
    localparam int          FILL_W   = 7;
    localparam int          MIN_BITS = 3;
    localparam logic [1:0]  ECG_TWOS = 2'd3;

    // Position of the highest set bit plus one; 0 for a zero input.
    function automatic int unsigned bit_len(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) n = i + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bp_group_controller_cpec.sv
// ----------------------------------------------------------------------------
// CPEC_encoder
// Combinational group-record builder. Produces the record for one group of
// four samples, left-aligned in an ACC_W-bit word (first bit at the MSB), and
// the record length in bits.
// Ports:
//   slots      in  4 x J   group samples, slot 0 = first sample
//   bits_req   in  HDR_W   field width B (already clamped)
//   ecgidx     in  2       coding mode latched with slot 0
//   group_skip in  1       all four samples are zero
//   record     out ACC_W   record bits, MSB-aligned, zero below the record
//   size       out FILL_W  record length: 4, 4+4B (two's) or 8+4B (SM)
// ----------------------------------------------------------------------------
module CPEC_encoder
    import bp_pkg::*;
#(
    parameter int J = 10
) (
    input  logic [3:0][J-1:0]  slots,
    input  logic [HDR_W-1:0]   bits_req,
    input  logic [1:0]         ecgidx,
    input  logic               group_skip,
    output logic [ACC_W-1:0]   record,
    output logic [FILL_W-1:0]  size
);

    logic          twos;
    logic [J-1:0]  mask;
    logic [J-1:0]  mag;
    logic [J-1:0]  field;
    logic [3:0]    signs;
    int            b;
    int            pos;

    // NOTE: every variable written in this block gets a value before any
    // branch, so no path leaves one holding its old value (no latches).
    always_comb begin
        record = '0;
        size   = '0;
        twos   = (ecgidx == ECG_TWOS);
        b      = int'(bits_req);
        mask   = J'((32'd1 << b) - 32'd1);
        mag    = '0;
        field  = '0;
        signs  = '0;
        pos    = 0;

        if (group_skip) begin
            // A skip record is just an all-zero header.
            size = FILL_W'(HDR_W);
        end else begin
            record[ACC_W-1 -: HDR_W] = bits_req;
            for (int i = 0; i < 4; i++) begin
                // -2^(J-1) negates to 2^(J-1), which still fits J unsigned bits.
                mag      = slots[i][J-1] ? (~slots[i] + J'(1)) : slots[i];
                field    = (twos ? slots[i] : mag) & mask;
                pos      = ACC_W - HDR_W - (i + 1) * b;
                record   = record | (ACC_W'(field) << pos);
                signs[3-i] = slots[i][J-1];
            end
            if (twos) begin
                size = FILL_W'(HDR_W + 4 * b);
            end else begin
                pos    = ACC_W - HDR_W - 4 * b - 4;
                record = record | (ACC_W'(signs) << pos);
                size   = FILL_W'(2 * HDR_W + 4 * b);
            end
        end
    end

endmodule

// File: rtl/bp_group_controller.sv
// ----------------------------------------------------------------------------
// bp_group_controller
// Collects signed samples in groups of four, encodes each group as a CPEC
// record (skip / two's complement / sign-magnitude) and packs the records
// MSB-first into W-bit output words through a 64-bit accumulator. A flush
// request closes a partial group and drains the residual bits zero-padded.
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   in_sample       J-bit signed sample, offered with in_valid
//   in_ready        sample accepted when high together with in_valid
//   ecgidx          coding mode (3 = two's complement, else SM)
//   flush           end-of-frame request (acted on only in COLLECT)
//   flush_done      one-cycle pulse when the flush has fully drained
//   out_word        packed bitstream word, MSB first
//   out_valid       out_word is valid; consumed when out_ready is high
//   out_ready       downstream accepts out_word
// The accumulator never overflows: a record (at most 8+4J bits) is appended
// only when fewer than W bits remain, and W-1+8+4J <= 63 for J=10, W=16.
// ----------------------------------------------------------------------------
module bp_group_controller
    import bp_pkg::*;
#(
    parameter int J = 10,
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [J-1:0]  in_sample,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           ecgidx,
    input  logic                 flush,
    output logic                 flush_done,
    output logic [W-1:0]         out_word,
    output logic                 out_valid,
    input  logic                 out_ready
);

    state_t               state, state_nxt;
    logic [2:0]           count;
    logic [3:0][J-1:0]    slots;
    logic [1:0]           mode;
    logic [ACC_W-1:0]     acc;
    logic [FILL_W-1:0]    fill;
    logic                 flush_pend;   // current EMIT was started by a flush

    logic [J-1:0]         or_mag;
    logic [J-1:0]         or_twos;
    int unsigned          b_raw;
    logic [HDR_W-1:0]     bits_req;
    logic                 group_skip;
    logic [ACC_W-1:0]     record;
    logic [FILL_W-1:0]    rec_size;
    logic                 have_word;

    assign have_word = (fill >= FILL_W'(W));

    // Bits_req: the bit length of the OR of all magnitudes equals the bit
    // length of the largest one. For two's complement, OR-ing v (or ~v for
    // negatives) gives the widest value bits; one more bit holds the sign.
    always_comb begin
        or_mag     = '0;
        or_twos    = '0;
        group_skip = 1'b1;
        for (int i = 0; i < 4; i++) begin
            or_mag  = or_mag  | (slots[i][J-1] ? (~slots[i] + J'(1)) : slots[i]);
            or_twos = or_twos | (slots[i][J-1] ? ~slots[i] : slots[i]);
            if (slots[i] != '0) group_skip = 1'b0;
        end
        if (mode == ECG_TWOS) b_raw = bit_len(32'(or_twos)) + 1;
        else                  b_raw = bit_len(32'(or_mag));
        if (b_raw < MIN_BITS)  b_raw = MIN_BITS;
        if (b_raw > J)         b_raw = J;
        bits_req = HDR_W'(b_raw);
    end

    CPEC_encoder #(.J(J)) u_cpec (
        .slots      (slots),
        .bits_req   (bits_req),
        .ecgidx     (mode),
        .group_skip (group_skip),
        .record     (record),
        .size       (rec_size)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_COLLECT;
        else     state <= state_nxt;
    end

    // Outputs are forced low while rst is high, whatever state is held.
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        flush_done = 1'b0;
        out_word   = '0;
        state_nxt  = state;

        if (!rst) begin
            in_ready   = (state == ST_COLLECT) && (count < 3'd4) && !flush;
            out_valid  = ((state == ST_EMIT)  && have_word) ||
                         ((state == ST_FLUSH) && (fill != '0));
            flush_done = (state == ST_FLUSH) && (fill == '0);
            // Bits below fill are always zero, so the FLUSH word is already
            // left-aligned and zero-padded.
            if (out_valid) out_word = acc[ACC_W-1 -: W];
        end

        unique case (state)
            ST_COLLECT: begin
                if (flush)
                    state_nxt = (count == 3'd0) ? ST_FLUSH : ST_ENCODE;
                else if (in_valid && in_ready && count == 3'd3)
                    state_nxt = ST_ENCODE;
            end
            ST_ENCODE: state_nxt = ST_EMIT;
            ST_EMIT: begin
                if (!have_word) state_nxt = flush_pend ? ST_FLUSH : ST_COLLECT;
            end
            ST_FLUSH: begin
                if (fill == '0) state_nxt = ST_COLLECT;
            end
            default: state_nxt = ST_COLLECT;
        endcase
    end

    // NOTE: the slot array is only four registers and feeds the skip
    // detector, so it is cleared by reset along with the rest of the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            slots      <= '0;
            mode       <= '0;
            acc        <= '0;
            fill       <= '0;
            flush_pend <= 1'b0;
        end else begin
            unique case (state)
                ST_COLLECT: begin
                    if (flush) begin
                        if (count != 3'd0) begin
                            for (int i = 0; i < 4; i++) begin
                                if (3'(i) >= count) slots[i] <= '0;
                            end
                            flush_pend <= 1'b1;
                        end
                    end else if (in_valid && in_ready) begin
                        slots[count[1:0]] <= in_sample;
                        if (count == 3'd0) mode <= ecgidx;
                        count <= count + 3'd1;
                    end
                end
                ST_ENCODE: begin
                    acc  <= acc | (record >> fill);
                    fill <= fill + rec_size;
                end
                ST_EMIT: begin
                    if (have_word) begin
                        if (out_ready) begin
                            acc  <= acc << W;
                            fill <= fill - FILL_W'(W);
                        end
                    end else begin
                        count <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (fill != '0) begin
                        if (out_ready) begin
                            acc  <= '0;
                            fill <= '0;
                        end
                    end else begin
                        flush_pend <= 1'b0;
                        count      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_group_controller.sv
// ----------------------------------------------------------------------------
// tb_bp_group_controller
// Directed and randomized stimulus for bp_group_controller. Expected output
// words come from a bit-queue model: each group record is built from the
// coding rules with integer arithmetic, appended to a queue of bits, and
// words are cut 16 bits at a time.
// ----------------------------------------------------------------------------
module tb_bp_group_controller;

    localparam int J = 10;
    localparam int W = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [J-1:0]  in_sample = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [1:0]           ecgidx = '0;
    logic                 flush = 1'b0;
    logic                 flush_done;
    logic [W-1:0]         out_word;
    logic                 out_valid;
    logic                 out_ready;

    bp_group_controller #(.J(J), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_sample  (in_sample),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ecgidx     (ecgidx),
        .flush      (flush),
        .flush_done (flush_done),
        .out_word   (out_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;

    // Reference model state
    bit            mq[$];
    int            grp[$];
    logic [1:0]    grp_mode = '0;
    logic [W-1:0]  exp_q[$];

    // Observed stream
    logic [W-1:0]  got_q[$];
    int            got_base = 0;
    int            done_cnt = 0;
    int            got_at_done = 0;

    // out_ready control
    bit            rdy_rand = 1'b0;
    bit            rdy_val  = 1'b1;

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got_q.push_back(out_word);
        if (!rst && flush_done) begin
            done_cnt    <= done_cnt + 1;
            got_at_done <= got_q.size();
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic drain_words();
        logic [W-1:0] wd;
        while (mq.size() >= W) begin
            wd = '0;
            for (int k = 0; k < W; k++) wd = {wd[W-2:0], mq.pop_front()};
            exp_q.push_back(wd);
        end
    endtask

    task automatic push_bits(input int val, input int nbits);
        for (int k = nbits - 1; k >= 0; k--) mq.push_back(bit'((val >> k) & 1));
    endtask

    task automatic model_encode();
        bit allz;
        int b;
        int m;
        allz = 1'b1;
        foreach (grp[i]) if (grp[i] != 0) allz = 1'b0;
        if (allz) begin
            push_bits(0, 4);
        end else begin
            if (grp_mode != 2'd3) begin
                b = 0;
                foreach (grp[i]) begin
                    m = (grp[i] < 0) ? -grp[i] : grp[i];
                    while ((1 << b) <= m) b++;
                end
            end else begin
                b = 1;
                foreach (grp[i])
                    while (!(grp[i] >= -(1 << (b - 1)) && grp[i] < (1 << (b - 1)))) b++;
            end
            if (b < 3) b = 3;
            if (b > J) b = J;
            push_bits(b, 4);
            foreach (grp[i]) begin
                m = (grp_mode == 2'd3) ? (grp[i] & ((1 << b) - 1))
                                       : ((grp[i] < 0) ? -grp[i] : grp[i]);
                push_bits(m, b);
            end
            if (grp_mode != 2'd3)
                foreach (grp[i]) mq.push_back(grp[i] < 0);
        end
        grp.delete();
        drain_words();
    endtask

    task automatic model_accept(input int v, input logic [1:0] idx);
        if (grp.size() == 0) grp_mode = idx;
        grp.push_back(v);
        if (grp.size() == 4) model_encode();
    endtask

    task automatic model_flush();
        if (grp.size() > 0) begin
            while (grp.size() < 4) grp.push_back(0);
            model_encode();
        end
        if (mq.size() > 0) begin
            while (mq.size() < W) mq.push_back(1'b0);
            drain_words();
        end
    endtask

    // ---------------- stimulus helpers ----------------
    // Every helper returns 1 time unit after a rising edge.
    task automatic send_sample(input int v, input logic [1:0] idx);
        bit ok;
        int n;
        int vv;
        vv        = v;
        ok        = 1'b0;
        n         = 0;
        in_sample = vv[J-1:0];
        ecgidx    = idx;
        in_valid  = 1'b1;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else n++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("sample_accepted", 64'(ok), 64'(1));
        if (ok) model_accept(v, idx);
    endtask

    task automatic send4(input int a, input int b, input int c, input int d, input logic [1:0] idx);
        send_sample(a, idx);
        send_sample(b, idx);
        send_sample(c, idx);
        send_sample(d, idx);
    endtask

    task automatic compare_words(input string tag);
        int n_got;
        n_got = got_q.size() - got_base;
        check({tag, "_word_count"}, 64'(n_got), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (got_base + i < got_q.size())
                check($sformatf("%s_word%0d", tag, i), 64'(got_q[got_base + i]), 64'(exp_q[i]));
        end
        got_base = got_q.size();
        exp_q.delete();
    endtask

    task automatic run_flush(input string tag, input bit with_valid);
        int n;
        int d0;
        int vv;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_reach_collect"}, 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        d0    = done_cnt;
        flush = 1'b1;
        if (with_valid) begin
            vv        = int'($urandom_range(0, 255)) + 1;
            in_sample = vv[J-1:0];
            in_valid  = 1'b1;
        end
        @(negedge clk);
        check({tag, "_in_ready_low_on_flush"}, 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        model_flush();
        n = 0;
        while (done_cnt == d0 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_flush_done_seen"}, 64'(done_cnt - d0), 64'(1));
        check({tag, "_words_before_done"}, 64'(got_at_done - got_base), 64'(exp_q.size()));
        repeat (3) begin @(posedge clk); #1; end
        check({tag, "_flush_done_once"}, 64'(done_cnt - d0), 64'(1));
        compare_words(tag);
    endtask

    function automatic int rand_sample();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return int'($urandom_range(0, 7)) - 4;
            2:       return int'($urandom_range(0, (1 << J) - 1)) - (1 << (J - 1));
            default: return ($urandom_range(0, 1) != 0) ? -(1 << (J - 1)) : (1 << (J - 1)) - 1;
        endcase
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [W-1:0] held;
        int           n;
        int           d0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready",   64'(in_ready),   64'(0));
        check("rst_out_valid",  64'(out_valid),  64'(0));
        check("rst_flush_done", 64'(flush_done), 64'(0));
        check("rst_out_word",   64'(out_word),   64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        // All-zero group: skip record, flush yields one zero word
        send4(0, 0, 0, 0, 2'd0);
        run_flush("zero_group", 1'b1);

        // Two's complement 3,-4,1,0: exactly one full word, then empty flush
        send4(3, -4, 1, 0, 2'd3);
        repeat (6) begin @(posedge clk); #1; end
        compare_words("twos_small");
        run_flush("twos_small_flush", 1'b0);

        // Sign-magnitude -5,2,0,1; later ecgidx changes must be ignored
        send_sample(-5, 2'd0);
        send_sample(2, 2'd3);
        send_sample(0, 2'd3);
        send_sample(1, 2'd1);
        run_flush("sm_group", 1'b0);

        // Partial group of two then flush
        send_sample(7, 2'd0);
        send_sample(-1, 2'd0);
        run_flush("partial_group", 1'b0);

        // Backpressure on a 44-bit record
        rdy_val = 1'b0;
        send4(-512, -512, -512, -512, 2'd3);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_out_valid", 64'(out_valid), 64'(1));
        held = out_word;
        d0   = done_cnt;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            flush     = (k == 1);
            in_sample = 10'sd5;
            in_valid  = 1'b1;
            @(negedge clk);
            check($sformatf("stall_word_c%0d", k), 64'(out_word), 64'(held));
            check($sformatf("stall_valid_c%0d", k), 64'(out_valid), 64'(1));
            check($sformatf("stall_in_ready_c%0d", k), 64'(in_ready), 64'(0));
        end
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        rdy_val  = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        check("flush_ignored_in_emit", 64'(done_cnt - d0), 64'(0));
        run_flush("stall_group", 1'b0);

        // Reset while a word is being offered in EMIT
        rdy_val = 1'b0;
        send4(-512, 100, -3, 511, 2'd3);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_out_valid", 64'(out_valid), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid",  64'(out_valid),  64'(0));
        check("mid_rst_in_ready",   64'(in_ready),   64'(0));
        check("mid_rst_flush_done", 64'(flush_done), 64'(0));
        check("mid_rst_out_word",   64'(out_word),   64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete();
        grp.delete();
        exp_q.delete();
        got_base = got_q.size();
        @(negedge clk);
        check("post_rst_in_ready",  64'(in_ready),  64'(1));
        check("post_rst_out_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        rdy_val = 1'b1;
        run_flush("post_rst_empty", 1'b0);

        // Randomized samples, modes, flushes and backpressure
        rdy_rand = 1'b1;
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 9) == 0)
                run_flush($sformatf("rand_flush%0d", it), 1'($urandom_range(0, 1)));
            else
                send_sample(rand_sample(), 2'($urandom_range(0, 3)));
        end
        run_flush("rand_final", 1'b0);
        rdy_rand = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
